dmem_port_arbiter: RTL and testbench

Shares the single data_memory port between two requesters: the processor MEM stage (cpu) and the serial debug/boot loader (dbg).
- Decides one grant per cycle.
- Drives the memory command combinationally in the grant cycle.
- Routes read data back to the owning requester one cycle later.
- Generates cpu_stall for the pipeline control.
- Fixed-priority mode with a starvation guard, or round-robin mode.

---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_grant_logic.sv | 37 +++
 rtl/dmem_port_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_port_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned CNT_W  = 4;

    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SIZE_W-1:0] size;
        logic              re;
        logic              we;
    } mem_cmd_t;

endpackage

// File: rtl/dmem_grant_logic.sv
// Combinational winner selection between cpu and dbg for the shared memory port.
module dmem_grant_logic
    import dmem_arb_pkg::*;
#(
    parameter int unsigned CPU_PRIORITY = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             cpuReq,
    input  logic             dbgReq,
    input  owner_e           lastOwner,
    input  logic [CNT_W-1:0] starveCnt,
    output logic             cpuGnt,
    output logic             dbgGnt
);

    logic dbgWins;

    // Contention goes to dbg on starvation (fixed priority) or by alternation (round robin).
    always_comb begin
        dbgWins = 1'b0;
        cpuGnt  = 1'b0;
        dbgGnt  = 1'b0;
        if (cpuReq && dbgReq) begin
            if (CPU_PRIORITY != 0) begin
                dbgWins = (starveCnt == CNT_W'(STARVE_LIMIT));
            end else begin
                dbgWins = (lastOwner == OWN_CPU);
            end
            cpuGnt = ~dbgWins;
            dbgGnt = dbgWins;
        end else begin
            cpuGnt = cpuReq;
            dbgGnt = dbgReq;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data_memory port between the cpu MEM stage and the debug loader,
// issuing one access per cycle and routing load data back one cycle later.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned CPU_PRIORITY = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [SIZE_W-1:0] cpu_size,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [SIZE_W-1:0] dbg_size,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [SIZE_W-1:0] mem_size,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_e           lastOwner;
    owner_e           rdOwner;
    owner_e           gntOwner;
    logic [CNT_W-1:0] starveCnt;
    logic             rdPend;
    logic             cpuReqQ;
    logic             dbgReqQ;
    logic             cpuGnt;
    logic             dbgGnt;
    mem_cmd_t         cmd;

    // Requests are ignored while reset is high so no access reaches memory.
    assign cpuReqQ = cpu_req & ~reset;
    assign dbgReqQ = dbg_req & ~reset;

    dmem_grant_logic #(
        .CPU_PRIORITY(CPU_PRIORITY),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant (
        .cpuReq   (cpuReqQ),
        .dbgReq   (dbgReqQ),
        .lastOwner(lastOwner),
        .starveCnt(starveCnt),
        .cpuGnt   (cpuGnt),
        .dbgGnt   (dbgGnt)
    );

    assign gntOwner = dbgGnt ? OWN_DBG : OWN_CPU;

    // Memory command mux; idle port drives all zeros.
    always_comb begin
        cmd = '0;
        if (cpuGnt) begin
            cmd = '{addr: cpu_addr, wdata: cpu_wdata, size: cpu_size, re: ~cpu_we, we: cpu_we};
        end else if (dbgGnt) begin
            cmd = '{addr: dbg_addr, wdata: dbg_wdata, size: dbg_size, re: ~dbg_we, we: dbg_we};
        end
    end

    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;
    assign mem_size  = cmd.size;
    assign mem_re    = cmd.re;
    assign mem_we    = cmd.we;

    always_ff @(posedge clock) begin
        if (reset) begin
            lastOwner <= OWN_CPU;
            starveCnt <= '0;
            rdPend    <= 1'b0;
            rdOwner   <= OWN_CPU;
        end else begin
            if (cpuGnt || dbgGnt) begin
                lastOwner <= gntOwner;
            end
            // Count contended cpu wins, saturating at the limit; a dbg win restarts the count.
            if (cpuReqQ && dbgReqQ) begin
                if (dbgGnt) begin
                    starveCnt <= '0;
                end else if (starveCnt < CNT_W'(STARVE_LIMIT)) begin
                    starveCnt <= starveCnt + CNT_W'(1);
                end
            end
            rdPend  <= cmd.re;
            rdOwner <= gntOwner;
        end
    end

    assign cpu_gnt    = cpuGnt;
    assign dbg_gnt    = dbgGnt;
    assign cpu_stall  = cpuReqQ & ~cpuGnt;
    assign cpu_rvalid = ~reset & rdPend & (rdOwner == OWN_CPU);
    assign dbg_rvalid = ~reset & rdPend & (rdOwner == OWN_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a fixed-priority and a round-robin instance share
// stimulus and are checked against a request-level model every cycle.
module tb_dmem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;
    logic [1:0]  cpu_size, dbg_size;

    // Index 0: CPU_PRIORITY=1, STARVE_LIMIT=4.  Index 1: round robin.
    logic [1:0]       cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_re, mem_we;
    logic [1:0][31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
    logic [1:0][1:0]  mem_size;

    int total = 0;
    int bad   = 0;

    // Model state per instance: owner codes 0 none, 1 cpu, 2 dbg.
    int mLast[2]   = '{1, 1};
    int mStreak[2] = '{0, 0};
    int mPend[2]   = '{0, 0};

    always #5 clock = ~clock;

    dmem_port_arbiter #(.CPU_PRIORITY(1), .STARVE_LIMIT(4)) u_fp (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_size(cpu_size), .cpu_gnt(cpu_gnt[0]), .cpu_stall(cpu_stall[0]),
        .cpu_rvalid(cpu_rvalid[0]), .cpu_rdata(cpu_rdata[0]),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_size(dbg_size), .dbg_gnt(dbg_gnt[0]), .dbg_rvalid(dbg_rvalid[0]),
        .dbg_rdata(dbg_rdata[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_re(mem_re[0]),
        .mem_we(mem_we[0]), .mem_size(mem_size[0]), .mem_rdata(mem_rdata)
    );

    dmem_port_arbiter #(.CPU_PRIORITY(0), .STARVE_LIMIT(4)) u_rr (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_size(cpu_size), .cpu_gnt(cpu_gnt[1]), .cpu_stall(cpu_stall[1]),
        .cpu_rvalid(cpu_rvalid[1]), .cpu_rdata(cpu_rdata[1]),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_size(dbg_size), .dbg_gnt(dbg_gnt[1]), .dbg_rvalid(dbg_rvalid[1]),
        .dbg_rdata(dbg_rdata[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_re(mem_re[1]),
        .mem_we(mem_we[1]), .mem_size(mem_size[1]), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: decide the winner from the request rules, then predict every output.
    always @(negedge clock) begin
        bit          cr, dr, we;
        int          g;
        logic [31:0] eAddr, eWdata;
        logic [1:0]  eSize;
        logic        eRvC, eRvD;
        string       tag;
        for (int m = 0; m < 2; m++) begin
            tag = (m == 0) ? "fp" : "rr";
            cr  = cpu_req && !reset;
            dr  = dbg_req && !reset;
            g   = 0;
            if (cr && dr) begin
                if (m == 0) g = (mStreak[m] == 4) ? 2 : 1;
                else        g = (mLast[m] == 1) ? 2 : 1;
            end else if (cr) g = 1;
            else if (dr)     g = 2;
            eAddr  = (g == 1) ? cpu_addr  : (g == 2) ? dbg_addr  : 32'h0;
            eWdata = (g == 1) ? cpu_wdata : (g == 2) ? dbg_wdata : 32'h0;
            eSize  = (g == 1) ? cpu_size  : (g == 2) ? dbg_size  : 2'b00;
            we     = (g == 1) ? cpu_we : (g == 2) ? dbg_we : 1'b0;
            eRvC   = !reset && mPend[m] == 1;
            eRvD   = !reset && mPend[m] == 2;

            chk({tag, " ctl"},
                32'({cpu_gnt[m], dbg_gnt[m], cpu_stall[m], mem_re[m], mem_we[m], cpu_rvalid[m], dbg_rvalid[m]}),
                32'({g == 1, g == 2, cr && g != 1, g != 0 && !we, g != 0 && we, eRvC, eRvD}));
            chk({tag, " mem_addr"}, mem_addr[m], eAddr);
            chk({tag, " mem_wdata"}, mem_wdata[m], eWdata);
            chk({tag, " mem_size"}, 32'(mem_size[m]), 32'(eSize));
            chk({tag, " cpu_rdata"}, cpu_rdata[m], eRvC ? mem_rdata : 32'h0);
            chk({tag, " dbg_rdata"}, dbg_rdata[m], eRvD ? mem_rdata : 32'h0);

            // Advance model to the state after the coming rising edge.
            if (reset) begin
                mLast[m] = 1; mStreak[m] = 0; mPend[m] = 0;
            end else begin
                if (g != 0) mLast[m] = g;
                if (cr && dr) mStreak[m] = (g == 1) ? ((mStreak[m] < 4) ? mStreak[m] + 1 : 4) : 0;
                mPend[m] = (g != 0 && !we) ? g : 0;
            end
        end
    end

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_size = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_size = 0;
    endtask

    initial begin
        idle();
        reset = 1; mem_rdata = 32'h0;
        cpu_req = 1; dbg_req = 1; cpu_addr = 32'h40; dbg_addr = 32'h80;

        // Reset with both requesting: nothing issues on either instance.
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            for (int m = 0; m < 2; m++)
                chk("reset quiet", 32'({cpu_gnt[m], dbg_gnt[m], mem_re[m], mem_we[m], cpu_rvalid[m], dbg_rvalid[m], cpu_stall[m]}), 32'h0);
            nextCycle();
        end
        reset = 0;

        // Continuous contention: fp gives cpu x4 then dbg; rr alternates starting with dbg.
        for (int i = 0; i < 10; i++) begin
            mem_rdata = $urandom;
            @(negedge clock);
            chk("fp pattern cpu_gnt", 32'(cpu_gnt[0]), 32'(i % 5 != 4));
            chk("fp pattern stall", 32'(cpu_stall[0]), 32'(i % 5 == 4));
            chk("rr pattern dbg_gnt", 32'(dbg_gnt[1]), 32'(i % 2 == 0));
            nextCycle();
        end

        // Single cpu word load and its return.
        dbg_req = 0; cpu_we = 0; cpu_addr = 32'h1000_0010; cpu_size = 2'b10;
        @(negedge clock);
        chk("ld cpu_gnt", 32'(cpu_gnt[0]), 32'h1);
        chk("ld mem_re", 32'(mem_re[0]), 32'h1);
        chk("ld mem_addr", mem_addr[0], 32'h1000_0010);
        nextCycle();
        cpu_req = 0; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("ld cpu_rvalid", 32'(cpu_rvalid[0]), 32'h1);
        chk("ld cpu_rdata", cpu_rdata[0], 32'hDEAD_BEEF);
        chk("ld dbg_rvalid", 32'(dbg_rvalid[0]), 32'h0);
        nextCycle();

        // Back-to-back cpu then dbg loads route to their own owners.
        cpu_req = 1; cpu_addr = 32'h200;
        @(negedge clock);
        nextCycle();
        cpu_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h300; mem_rdata = 32'h1111_1111;
        @(negedge clock);
        chk("b2b cpu_rdata", cpu_rdata[0], 32'h1111_1111);
        chk("b2b dbg_rvalid early", 32'(dbg_rvalid[0]), 32'h0);
        nextCycle();
        dbg_req = 0; mem_rdata = 32'h2222_2222;
        @(negedge clock);
        chk("b2b dbg_rdata", dbg_rdata[0], 32'h2222_2222);
        chk("b2b cpu_rvalid late", 32'(cpu_rvalid[0]), 32'h0);
        nextCycle();

        // dbg byte store, then cpu load interrupted by reset.
        dbg_req = 1; dbg_we = 1; dbg_wdata = 32'h55; dbg_size = 2'b00; dbg_addr = 32'hFFFF_0004;
        @(negedge clock);
        chk("st mem_we", 32'({mem_we[0], mem_re[0]}), 32'h2);
        chk("st mem_wdata", mem_wdata[0], 32'h55);
        nextCycle();
        idle(); cpu_req = 1;
        @(negedge clock);
        chk("st no dbg_rvalid", 32'(dbg_rvalid[0]), 32'h0);
        nextCycle();
        cpu_req = 0; reset = 1;
        @(negedge clock);
        chk("rst kills cpu_rvalid", 32'(cpu_rvalid[0]), 32'h0);
        nextCycle();
        reset = 0;

        // Random traffic, occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(63) == 0);
            cpu_req   = ($urandom_range(3) != 0);
            cpu_we    = $urandom_range(1);
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            cpu_size  = 2'($urandom_range(3));
            dbg_req   = $urandom_range(1);
            dbg_we    = $urandom_range(1);
            dbg_addr  = $urandom;
            dbg_wdata = $urandom;
            dbg_size  = 2'($urandom_range(3));
            mem_rdata = $urandom;
            nextCycle();
        end

        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
